// File: rtl/bit_stream_serializer_if.sv
// Word-load handshake and serial output bundle for bit_stream_serializer.
// The master is the word source and the slave is the serializer.
interface bit_stream_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_bit;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_data, load_valid,
    input  load_ready, ser_bit, bit_valid, busy, frame_done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, ser_bit, bit_valid, busy, frame_done
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words and streams them bit by bit,
// with gap-free reload on the final clock of a word.
module bit_stream_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int BIT_CYCLES = 1,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  bit_stream_serializer_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_cyc_cnt;
  logic             r_ser_bit;
  logic             r_bit_valid;
  logic             r_busy;

  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;
  logic             w_next_bit;
  logic             w_first_bit;

  assign w_last   = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT) && (r_cyc_cnt == LAST_CYC);
  assign w_ready  = !reset && ((r_state == S_IDLE) || w_last);
  assign w_accept = w_ready && bus.load_valid;

  always_comb begin
    w_shifted   = '0;
    w_next_bit  = 1'b0;
    w_first_bit = 1'b0;
    if (MSB_FIRST) begin
      w_shifted   = {r_shift[WIDTH-2:0], 1'b0};
      w_next_bit  = w_shifted[WIDTH-1];
      w_first_bit = bus.load_data[WIDTH-1];
    end else begin
      w_shifted   = {1'b0, r_shift[WIDTH-1:1]};
      w_next_bit  = w_shifted[0];
      w_first_bit = bus.load_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_cyc_cnt   <= '0;
      r_ser_bit   <= IDLE_BIT;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      // Covers both the idle load and the gap-free reload on the final clock.
      r_state     <= S_SHIFT;
      r_shift     <= bus.load_data;
      r_bit_cnt   <= '0;
      r_cyc_cnt   <= '0;
      r_ser_bit   <= w_first_bit;
      r_bit_valid <= 1'b1;
      r_busy      <= 1'b1;
    end else if (r_state == S_SHIFT) begin
      if (w_last) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= '0;
        r_cyc_cnt   <= '0;
        r_ser_bit   <= IDLE_BIT;
        r_bit_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else if (r_cyc_cnt == LAST_CYC) begin
        r_shift   <= w_shifted;
        r_ser_bit <= w_next_bit;
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_cyc_cnt <= '0;
      end else begin
        r_cyc_cnt <= r_cyc_cnt + 1'b1;
      end
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.ser_bit    = r_ser_bit;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = w_last && !reset;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: three parameterisations, a vector table, corner
// sequences and random traffic checked against a frame-level reference model.
module tb_bit_stream_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[3];
  logic       lv[3];
  logic [7:0] ld[3];
  logic       o_ser[3], o_bv[3], o_rdy[3], o_done[3], o_busy[3];

  // Instance 0: MSB first, 1 clk/bit. Instance 1: MSB first, 3 clk/bit. Instance 2: LSB first, idle high.
  int   P_MSB[3]  = '{1, 1, 0};
  int   P_BC[3]   = '{1, 3, 1};
  logic P_IDLE[3] = '{1'b0, 1'b0, 1'b1};

  bit_stream_serializer_if #(.WIDTH(8)) ifa ();
  bit_stream_serializer_if #(.WIDTH(8)) ifb ();
  bit_stream_serializer_if #(.WIDTH(8)) ifc ();

  assign ifa.load_valid = lv[0];
  assign ifa.load_data  = ld[0];
  assign ifb.load_valid = lv[1];
  assign ifb.load_data  = ld[1];
  assign ifc.load_valid = lv[2];
  assign ifc.load_data  = ld[2];
  assign o_ser[0] = ifa.ser_bit;  assign o_bv[0] = ifa.bit_valid;  assign o_rdy[0] = ifa.load_ready;
  assign o_done[0] = ifa.frame_done;  assign o_busy[0] = ifa.busy;
  assign o_ser[1] = ifb.ser_bit;  assign o_bv[1] = ifb.bit_valid;  assign o_rdy[1] = ifb.load_ready;
  assign o_done[1] = ifb.frame_done;  assign o_busy[1] = ifb.busy;
  assign o_ser[2] = ifc.ser_bit;  assign o_bv[2] = ifc.bit_valid;  assign o_rdy[2] = ifc.load_ready;
  assign o_done[2] = ifc.frame_done;  assign o_busy[2] = ifc.busy;

  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .BIT_CYCLES(1), .IDLE_BIT(1'b0))
    u_a (.clk(clk), .reset(rst[0]), .bus(ifa.slave));
  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .BIT_CYCLES(3), .IDLE_BIT(1'b0))
    u_b (.clk(clk), .reset(rst[1]), .bus(ifb.slave));
  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .BIT_CYCLES(1), .IDLE_BIT(1'b1))
    u_c (.clk(clk), .reset(rst[2]), .bus(ifc.slave));

  int passed = 0;
  int total  = 0;

  // Reference model: whether a frame is active, its word, and the clock index within it.
  logic       m_act[3];
  logic [7:0] m_w[3];
  int         m_t[3];

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
  endtask

  function automatic logic mbit(input int k, input logic [7:0] w, input int i);
    return (P_MSB[k] != 0) ? w[7-i] : w[i];
  endfunction

  // One clock on instance k: drive inputs, compare against the model, advance the model.
  task automatic step(input int k, input logic r, input logic v, input logic [7:0] d,
                      output logic s, output logic bv, output logic rdy,
                      output logic dn, output logic bz);
    int   last;
    logic e_rdy;
    rst[k] = r;
    lv[k]  = v;
    ld[k]  = d;
    last   = 8 * P_BC[k] - 1;
    @(negedge clk);
    s = o_ser[k]; bv = o_bv[k]; rdy = o_rdy[k]; dn = o_done[k]; bz = o_busy[k];
    e_rdy = !r && (!m_act[k] || m_t[k] == last);
    chk("model_ser",   k, s,   m_act[k] ? mbit(k, m_w[k], m_t[k] / P_BC[k]) : P_IDLE[k]);
    chk("model_valid", k, bv,  m_act[k]);
    chk("model_busy",  k, bz,  m_act[k]);
    chk("model_ready", k, rdy, e_rdy);
    chk("model_done",  k, dn,  !r && m_act[k] && m_t[k] == last);
    @(posedge clk);
    if (r) m_act[k] = 1'b0;
    else if (v && e_rdy) begin
      m_act[k] = 1'b1;
      m_w[k]   = d;
      m_t[k]   = 0;
    end else if (m_act[k]) begin
      if (m_t[k] == last) m_act[k] = 1'b0;
      else m_t[k]++;
    end
    #1;
  endtask

  typedef struct {
    logic       r, v;
    logic [7:0] d;
    logic       ser, bv, rdy, done, busy;
  } vec_t;

  vec_t vt[11];
  logic s, bv, rdy, dn, bz;
  logic [15:0] stream;

  initial begin
    vt[0]  = '{1'b1, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; lv[k] = 1'b0; ld[k] = 8'h00; m_act[k] = 1'b0; m_w[k] = 8'h00; m_t[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Table: 8'h37 MSB first, including load_ready low during reset.
    for (int i = 0; i < 11; i++) begin
      step(0, vt[i].r, vt[i].v, vt[i].d, s, bv, rdy, dn, bz);
      chk("tbl_ser",   i, s,   vt[i].ser);
      chk("tbl_valid", i, bv,  vt[i].bv);
      chk("tbl_ready", i, rdy, vt[i].rdy);
      chk("tbl_done",  i, dn,  vt[i].done);
      chk("tbl_busy",  i, bz,  vt[i].busy);
    end

    // Back-to-back B5 then 3C: contiguous 16 bits, no valid gap.
    step(0, 1'b0, 1'b1, 8'hB5, s, bv, rdy, dn, bz);
    stream = '0;
    for (int c = 1; c <= 16; c++) begin
      step(0, 1'b0, (c <= 8), 8'h3C, s, bv, rdy, dn, bz);
      stream = {stream[14:0], s};
      chk("b2b_valid", c, bv,  1'b1);
      chk("b2b_ready", c, rdy, (c == 8 || c == 16));
      chk("b2b_done",  c, dn,  (c == 8 || c == 16));
    end
    total++;
    if (stream == 16'hB53C) passed++;
    else $display("FAIL b2b_stream: got %h expected b53c", stream);
    step(0, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);
    chk("b2b_idle_valid", 0, bv, 1'b0);

    // LSB first 8'h01, idle level high.
    step(2, 1'b0, 1'b1, 8'h01, s, bv, rdy, dn, bz);
    for (int c = 1; c <= 9; c++) begin
      step(2, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);
      chk("lsb_ser",  c, s,  (c == 1 || c == 9));
      chk("lsb_done", c, dn, (c == 8));
      chk("lsb_valid", c, bv, (c <= 8));
    end

    // 3 clocks per bit, 8'hA0; a second word offered from cycle 10 waits until cycle 24.
    step(1, 1'b0, 1'b1, 8'hA0, s, bv, rdy, dn, bz);
    for (int c = 1; c <= 25; c++) begin
      logic [7:0] a0;
      a0 = 8'hA0;
      step(1, 1'b0, (c >= 10), 8'h5A, s, bv, rdy, dn, bz);
      if (c <= 24) chk("bc3_ser", c, s, a0[7 - (c - 1) / 3]);
      chk("bc3_ready", c, rdy, (c == 24));
      chk("bc3_done",  c, dn,  (c == 24));
      if (c == 25) begin
        chk("bc3_reload_valid", c, bv, 1'b1);
        chk("bc3_reload_ser",   c, s,  1'b0);
      end
    end
    repeat (24) step(1, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);

    // Reset mid-frame of 8'hFF; the word held during reset is taken right after.
    step(0, 1'b0, 1'b1, 8'hFF, s, bv, rdy, dn, bz);
    for (int c = 1; c <= 3; c++) step(0, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);
    step(0, 1'b1, 1'b1, 8'h81, s, bv, rdy, dn, bz);
    chk("rst_ready_low", 0, rdy, 1'b0);
    step(0, 1'b0, 1'b1, 8'h81, s, bv, rdy, dn, bz);
    chk("rst_after_ser",   0, s,   1'b0);
    chk("rst_after_valid", 0, bv,  1'b0);
    chk("rst_after_busy",  0, bz,  1'b0);
    chk("rst_after_done",  0, dn,  1'b0);
    chk("rst_after_ready", 0, rdy, 1'b1);
    step(0, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);
    chk("rst_reload_ser",   0, s,  1'b1);
    chk("rst_reload_valid", 0, bv, 1'b1);
    repeat (8) step(0, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);

    // Random traffic with occasional resets on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 400; n++) begin
        step(k, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             8'($urandom), s, bv, rdy, dn, bz);
      end
      repeat (30) step(k, 1'b0, 1'b0, 8'h00, s, bv, rdy, dn, bz);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
